// File: rtl/pwm_meas.sv
// PWM period / high-time meter with synchronizer, timeout and saturating counters.
// Optional serial duty-ratio divider is built only when PWM_MEAS_DUTY_EN is defined.
module pwm_meas #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout,
  output logic             level,
  output logic [7:0]       duty,
  output logic             duty_valid,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             sync1_q, sync_q, prev_q;
  logic             rise;
  logic [CNT_W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
  logic             armed_q, armed_d, timeout_q, timeout_d, meas_q, meas_d;

  assign rise = sync_q & ~prev_q;

  // A rise always wins over saturation, so timeout only fires on a quiet cycle.
  always_comb begin
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    period_d  = period_q;
    high_d    = high_q;
    armed_d   = armed_q;
    timeout_d = timeout_q;
    meas_d    = 1'b0;
    if (rise) begin
      cnt_d     = CNT_W'(1);
      hcnt_d    = CNT_W'(1);
      armed_d   = 1'b1;
      timeout_d = 1'b0;
      if (armed_q) begin
        period_d = cnt_q;
        high_d   = hcnt_q;
        meas_d   = 1'b1;
      end
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      if (sync_q && hcnt_q != CNT_MAX) hcnt_d = hcnt_q + CNT_W'(1);
      if (cnt_q == CNT_MAX) begin
        timeout_d = 1'b1;
        armed_d   = 1'b0;
        period_d  = '0;
        high_d    = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync_q    <= 1'b0;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      armed_q   <= 1'b0;
      timeout_q <= 1'b0;
      meas_q    <= 1'b0;
    end else begin
      sync1_q   <= pwm_in;
      sync_q    <= sync1_q;
      prev_q    <= sync_q;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      armed_q   <= armed_d;
      timeout_q <= timeout_d;
      meas_q    <= meas_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = meas_q;
  assign timeout    = timeout_q;
  assign level      = sync_q;

`ifdef PWM_MEAS_DUTY_EN
  logic             busy_q, busy_d, dv_q, dv_d, sat_q, sat_d;
  logic [2:0]       bit_q, bit_d;
  logic [CNT_W-1:0] rem_q, rem_d, div_q, div_d;
  logic [CNT_W:0]   shifted;
  logic [7:0]       quo_q, quo_d, duty_q, duty_d;

  // Restoring division of high_time*256 by period; high >= period clamps to full scale.
  always_comb begin
    busy_d  = busy_q;
    dv_d    = 1'b0;
    sat_d   = sat_q;
    bit_d   = bit_q;
    rem_d   = rem_q;
    div_d   = div_q;
    quo_d   = quo_q;
    duty_d  = duty_q;
    shifted = {rem_q, 1'b0};
    if (meas_q && period_q != '0) begin
      busy_d = 1'b1;
      bit_d  = 3'd0;
      rem_d  = high_q;
      div_d  = period_q;
      sat_d  = (high_q >= period_q);
      quo_d  = 8'd0;
    end else if (busy_q) begin
      if (shifted >= {1'b0, div_q}) begin
        rem_d = CNT_W'(shifted - {1'b0, div_q});
        quo_d = {quo_q[6:0], 1'b1};
      end else begin
        rem_d = shifted[CNT_W-1:0];
        quo_d = {quo_q[6:0], 1'b0};
      end
      bit_d = bit_q + 3'd1;
      if (bit_q == 3'd7) begin
        busy_d = 1'b0;
        dv_d   = 1'b1;
        duty_d = sat_q ? 8'hFF : quo_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      dv_q   <= 1'b0;
      sat_q  <= 1'b0;
      bit_q  <= 3'd0;
      rem_q  <= '0;
      div_q  <= '0;
      quo_q  <= 8'd0;
      duty_q <= 8'd0;
    end else begin
      busy_q <= busy_d;
      dv_q   <= dv_d;
      sat_q  <= sat_d;
      bit_q  <= bit_d;
      rem_q  <= rem_d;
      div_q  <= div_d;
      quo_q  <= quo_d;
      duty_q <= duty_d;
    end
  end

  assign duty       = duty_q;
  assign duty_valid = dv_q;
  assign busy       = busy_q;
`else
  assign duty       = 8'd0;
  assign duty_valid = 1'b0;
  assign busy       = 1'b0;
`endif

endmodule

// File: doc/pwm_meas.md
PWM_MEAS -- requirements
Module: pwm_meas

Interface
REQ-001 SHALL have parameter CNT_W, default 8, counter and result width in bits (legal range 4..16).
REQ-002 SHALL have port clk  input  1  single clock; all flops on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port pwm_in  input  1  PWM waveform under measurement, asynchronous to clk.
REQ-005 SHALL have port period  output  CNT_W  last measured period in clk cycles.
REQ-006 SHALL have port high_time  output  CNT_W  last measured high time in clk cycles.
REQ-007 SHALL have port meas_valid  output  1  one-cycle pulse when period/high_time update.
REQ-008 SHALL have port timeout  output  1  level; no rising edge within 2^CNT_W-1 cycles.
REQ-009 SHALL have port level  output  1  synchronized pwm_in level.
REQ-010 SHALL have port duty  output  8  duty ratio, 0..255 full scale.
REQ-011 SHALL have port duty_valid  output  1  one-cycle pulse when duty updates.
REQ-012 SHALL have port busy  output  1  duty divider running.

Function
REQ-013 SHALL pass pwm_in through a 2-flop synchronizer to s; level = s.
REQ-014 SHALL flag rise in the cycle where s=1 and the previous s=0.
REQ-015 Counters cnt/hcnt: on rise, cnt<=1, hcnt<=1; otherwise cnt<=cnt+1 and hcnt<=hcnt+s, both saturating at 2^CNT_W-1.
REQ-016 On rise with armed=1, SHALL register period<=cnt and high_time<=hcnt, then pulse meas_valid the next cycle.
REQ-017 Armed SHALL be cleared by reset and by timeout, and SHALL be set on any rise; the first rise after reset or timeout produces no meas_valid.
REQ-018 When cnt reaches 2^CNT_W-1 without a rise, SHALL set timeout=1, clear armed, and set period=0 and high_time=0.
REQ-019 Timeout SHALL clear on the next rise.
REQ-020 Example: a steady period of 10 cycles with 3 high cycles yields period=10 and high_time=3.
REQ-021 Rise and saturation in the same cycle: rise SHALL win; no timeout.

Reset
REQ-022 While rst_n=0, all flops SHALL clear: period=0, high_time=0, meas_valid=0, timeout=0, level=0, duty=0, duty_valid=0, busy=0, armed=0, synchronizer=0.
REQ-023 Reset mid-division SHALL abort the division with no duty_valid.

Configuration
REQ-024 With PWM_MEAS_DUTY_EN defined, a serial restoring divider SHALL start on each meas_valid.
- Computes duty = min(255, floor(high_time*256/period)), one quotient bit per cycle.
- busy=1 for 8 cycles, then duty updates and duty_valid pulses in the following cycle.
- A meas_valid while busy restarts the divider with the new operands.
- period=0 is never divided.
REQ-025 Without PWM_MEAS_DUTY_EN, duty, duty_valid and busy SHALL be tied to 0 and no divider logic SHALL be present.

Verification
REQ-026 Period 10, high 3, three periods -> meas_valid pulses at the 2nd and 3rd rises, period=10, high_time=3, no pulse at the 1st rise.
REQ-027 pwm_in held at 0 for 300 cycles with CNT_W=8 -> timeout=1 at cnt=255, period=0, high_time=0; the next two rises clear timeout and then give one valid measurement.
REQ-028 100% duty (pwm_in stuck at 1) after valid periods -> timeout asserts, level=1, high_time=0.
REQ-029 DUTY_EN: period 20, high 5 -> busy for 8 cycles, duty=64, one duty_valid pulse; period 4, high 4 -> duty=255.
REQ-030 rst_n pulled low during busy -> all outputs 0 immediately, no duty_valid after release, the first post-reset rise is not measured.
